// File: rtl/ds18b20_slave_emu.sv
// ds18b20_slave_emu
//   1-Wire responder that behaves like a single DS18B20 on the dq line.
//   It answers reset with a presence pulse, accepts Skip ROM (0xCC) followed
//   by a function command, runs Convert T (0x44) and serves the scratchpad
//   on Read Scratchpad (0xBE). The line is open-drain: dq is driven low or
//   released, never driven high.
//
//   Optional feature macro: SCRATCH_CRC_EN
//     defined   : a read returns all 9 scratchpad bytes, byte 8 is the Dallas
//                 CRC8 of bytes 0..7; rd_done follows bit 71.
//     undefined : a read returns bytes 0..1 only; rd_done follows bit 15 and
//                 later read slots see a released bus. No CRC logic exists.
//
// Ports
//   sys_clk    in   1   system clock
//   sys_rst_n  in   1   asynchronous active-low reset
//   dq         io   1   1-Wire data line (driven 0 or Z only)
//   temp_raw   in  16   temperature captured at the end of a conversion
//   cmd_code   out  8   last function command received
//   cmd_valid  out  1   one-cycle pulse when cmd_code updates
//   conv_busy  out  1   high while Convert T runs
//   rd_done    out  1   one-cycle pulse after the last scratchpad bit
//   state_dbg  out  3   current FSM state (debug visibility)
//
// Slot handshake: a slot begins on a falling edge of dq that this block did
// not cause; it stays open for max(SAMPLE_US, HOLD0_US) ticks and any fall
// inside that window is ignored. Write bits are sampled at SAMPLE_US ticks,
// read-slot zeros are driven from tick 1 through tick HOLD0_US.
module ds18b20_slave_emu #(
  parameter int CLK_PER_US   = 50,
  parameter int RST_MIN_US   = 400,
  parameter int PRES_WAIT_US = 30,
  parameter int PRES_LEN_US  = 120,
  parameter int SAMPLE_US    = 30,
  parameter int HOLD0_US     = 30,
  parameter int CONV_US      = 750000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  inout  wire         dq,
  input  logic [15:0] temp_raw,
  output logic [7:0]  cmd_code,
  output logic        cmd_valid,
  output logic        conv_busy,
  output logic        rd_done,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRES_WAIT = 3'd1,
    PRES_DRV  = 3'd2,
    ROM_RX    = 3'd3,
    FUNC_RX   = 3'd4,
    TX        = 3'd5,
    STAT      = 3'd6
  } state_t;

  localparam int DIVW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_PER_US - 1);

  localparam int LOWW = $clog2(RST_MIN_US + 1);
  localparam logic [LOWW-1:0] LOW_MAX = LOWW'(RST_MIN_US);

  localparam int ST_MAX = (PRES_WAIT_US > PRES_LEN_US) ? PRES_WAIT_US : PRES_LEN_US;
  localparam int STW = $clog2(ST_MAX + 1);
  localparam logic [STW-1:0] PW_LAST = STW'(PRES_WAIT_US - 1);
  localparam logic [STW-1:0] PL_LAST = STW'(PRES_LEN_US - 1);

  localparam int SLOT_MAX = (SAMPLE_US > HOLD0_US) ? SAMPLE_US : HOLD0_US;
  localparam int SLW = $clog2(SLOT_MAX + 1);
  localparam logic [SLW-1:0] SAMPLE_LAST = SLW'(SAMPLE_US - 1);
  localparam logic [SLW-1:0] HOLD_LAST   = SLW'(HOLD0_US - 1);
  localparam logic [SLW-1:0] SLOT_LAST   = SLW'(SLOT_MAX - 1);

  localparam int CONVW = $clog2(CONV_US + 1);
  localparam logic [CONVW-1:0] CONV_LAST = CONVW'(CONV_US - 1);

`ifdef SCRATCH_CRC_EN
  localparam int TXN = 72;
`else
  localparam int TXN = 16;
`endif
  localparam logic [6:0] TX_LAST = 7'(TXN - 1);

  state_t            state;
  logic [DIVW-1:0]   div_cnt;
  logic              tick;
  logic              dq_s1, dq_s2, dq_s3;
  logic              drive_low;
  logic [3:0]        drv_hist;
  logic              masked, fall, rise, bus_reset;
  logic [LOWW-1:0]   low_cnt;
  logic              slot_active;
  logic [SLW-1:0]    slot_us;
  logic              ev_start, ev_sample, ev_hold_end;
  logic [STW-1:0]    st_us;
  logic [6:0]        bit_cnt;
  logic [7:0]        rx_sr;
  logic [7:0]        rx_next;
  logic [TXN-1:0]    tx_sr;
  logic [TXN-1:0]    tx_load;
  logic [15:0]       temp_reg;
  logic [CONVW-1:0]  conv_cnt;

  assign dq        = drive_low ? 1'b0 : 1'bz;
  assign state_dbg = state;

  // 1 us timebase
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

  // Synchronizer plus a short history of our own drive, so that edges we
  // create (and their synchronizer echo) are not mistaken for master activity.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dq_s1    <= 1'b1;
      dq_s2    <= 1'b1;
      dq_s3    <= 1'b1;
      drv_hist <= '0;
    end else begin
      dq_s1    <= dq;
      dq_s2    <= dq_s1;
      dq_s3    <= dq_s2;
      drv_hist <= {drv_hist[2:0], drive_low};
    end
  end

  assign masked    = drive_low | (|drv_hist);
  assign fall      = dq_s3 & ~dq_s2 & ~masked;
  assign rise      = ~dq_s3 & dq_s2;
  assign bus_reset = rise & ~masked & (low_cnt == LOW_MAX);
  assign rx_next   = {dq_s2, rx_sr[7:1]};

  // Master low-time measurement, saturating at the reset threshold.
  // It holds (does not count) while we are the one pulling the line.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      low_cnt <= '0;
    end else if (rise) begin
      low_cnt <= '0;
    end else if (!dq_s2 && !masked && tick && (low_cnt != LOW_MAX)) begin
      low_cnt <= low_cnt + 1'b1;
    end
  end

  // Slot timer: counts ticks from the accepted falling edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      slot_active <= 1'b0;
      slot_us     <= '0;
    end else if (bus_reset) begin
      slot_active <= 1'b0;
      slot_us     <= '0;
    end else if (fall && !slot_active) begin
      slot_active <= 1'b1;
      slot_us     <= '0;
    end else if (slot_active && tick) begin
      slot_us <= slot_us + 1'b1;
      if (slot_us == SLOT_LAST) slot_active <= 1'b0;
    end
  end

  assign ev_start    = slot_active & tick & (slot_us == '0);
  assign ev_sample   = slot_active & tick & (slot_us == SAMPLE_LAST);
  assign ev_hold_end = slot_active & tick & (slot_us == HOLD_LAST);

  // Convert T: a new 0x44 restarts the timer; a bus reset does not stop it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      conv_busy <= 1'b0;
      conv_cnt  <= '0;
      temp_reg  <= 16'h0550;
    end else if (cmd_valid && (cmd_code == 8'h44)) begin
      conv_busy <= 1'b1;
      conv_cnt  <= '0;
    end else if (conv_busy && tick) begin
      if (conv_cnt == CONV_LAST) begin
        conv_busy <= 1'b0;
        temp_reg  <= temp_raw;
      end else begin
        conv_cnt <= conv_cnt + 1'b1;
      end
    end
  end

`ifdef SCRATCH_CRC_EN
  // Dallas/Maxim CRC8, reflected polynomial 0x8C, LSB first, init 0
  function automatic logic [7:0] crc8(input logic [63:0] d);
    logic [7:0] c;
    logic       mix;
    c = 8'h00;
    for (int i = 0; i < 64; i++) begin
      mix = c[0] ^ d[i];
      c   = c >> 1;
      if (mix) c = c ^ 8'h8C;
    end
    return c;
  endfunction

  logic [63:0] scratch;
  // Byte 0 in the low bits so the shift register sends it first.
  // The CRC follows temp_reg combinationally, so it is fresh after every capture.
  assign scratch = {8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, temp_reg};
  assign tx_load = {crc8(scratch), scratch};
`else
  assign tx_load = temp_reg;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      st_us     <= '0;
      bit_cnt   <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      drive_low <= 1'b0;
      cmd_code  <= 8'h00;
      cmd_valid <= 1'b0;
      rd_done   <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      rd_done   <= 1'b0;
      if (bus_reset) begin
        // Aborts any rx/tx in progress from whatever state we are in.
        state     <= PRES_WAIT;
        st_us     <= '0;
        bit_cnt   <= '0;
        drive_low <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          PRES_WAIT: begin
            if (tick) begin
              if (st_us == PW_LAST) begin
                state     <= PRES_DRV;
                st_us     <= '0;
                drive_low <= 1'b1;
              end else begin
                st_us <= st_us + 1'b1;
              end
            end
          end
          PRES_DRV: begin
            if (tick) begin
              if (st_us == PL_LAST) begin
                drive_low <= 1'b0;
                st_us     <= '0;
                bit_cnt   <= '0;
                state     <= ROM_RX;
              end else begin
                st_us <= st_us + 1'b1;
              end
            end
          end
          ROM_RX: begin
            if (ev_sample) begin
              rx_sr <= rx_next;
              if (bit_cnt == 7'd7) begin
                bit_cnt <= '0;
                state   <= (rx_next == 8'hCC) ? FUNC_RX : IDLE;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          FUNC_RX: begin
            if (ev_sample) begin
              rx_sr <= rx_next;
              if (bit_cnt == 7'd7) begin
                bit_cnt   <= '0;
                cmd_code  <= rx_next;
                cmd_valid <= 1'b1;
                case (rx_next)
                  8'h44:   state <= STAT;
                  8'hBE: begin
                    tx_sr <= tx_load;
                    state <= TX;
                  end
                  default: state <= IDLE;
                endcase
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          TX: begin
            if (ev_start && !tx_sr[0]) drive_low <= 1'b1;
            if (ev_hold_end) begin
              drive_low <= 1'b0;
              tx_sr     <= tx_sr >> 1;
              if (bit_cnt == TX_LAST) begin
                bit_cnt <= '0;
                rd_done <= 1'b1;
                state   <= IDLE;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          STAT: begin
            // Busy reads back as 0, done as 1 (released).
            if (ev_start && conv_busy) drive_low <= 1'b1;
            if (ev_hold_end) drive_low <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ds18b20_slave_emu.sv
module tb_ds18b20_slave_emu;

  localparam int CPU = 2;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ROM_RX = 3'd3;
  localparam logic [2:0] S_TX     = 3'd5;
  localparam logic [2:0] S_STAT   = 3'd6;

  logic        sys_clk;
  logic        sys_rst_n;
  wire         dq;
  logic        m_low;
  logic [15:0] temp_raw;
  logic [7:0]  cmd_code;
  logic        cmd_valid;
  logic        conv_busy;
  logic        rd_done;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  // monitor bookkeeping
  int         cyc = 0;
  int         cmd_cnt = 0;
  logic [7:0] last_cmd = 8'h00;
  int         rd_cnt = 0;
  logic       busy_prev = 1'b0;
  int         busy_rise = 0;
  int         busy_fall = 0;

  logic [7:0] exp_q[$];

  assign dq = m_low ? 1'b0 : 1'bz;
  pullup (dq);

  ds18b20_slave_emu #(
    .CLK_PER_US(CPU),
    .CONV_US   (200)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .dq       (dq),
    .temp_raw (temp_raw),
    .cmd_code (cmd_code),
    .cmd_valid(cmd_valid),
    .conv_busy(conv_busy),
    .rd_done  (rd_done),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    cyc = cyc + 1;
    if (cmd_valid) begin
      cmd_cnt  = cmd_cnt + 1;
      last_cmd = cmd_code;
    end
    if (rd_done) rd_cnt = rd_cnt + 1;
    if (conv_busy && !busy_prev) busy_rise = cyc;
    if (!conv_busy && busy_prev) busy_fall = cyc;
    busy_prev = conv_busy;
  end

  // driver tasks
  task automatic wait_us(input int n);
    repeat (n * CPU) @(posedge sys_clk);
    #1;
  endtask

  task automatic bus_reset(output int first, output int last);
    first = -1;
    last  = -1;
    m_low = 1'b1;
    wait_us(500);
    m_low = 1'b0;
    for (int i = 1; i <= 250; i++) begin
      wait_us(1);
      if (dq === 1'b0) begin
        if (first < 0) first = i;
        last = i;
      end
    end
  endtask

  task automatic write_bit(input logic b);
    m_low = 1'b1;
    if (b) begin
      wait_us(2);
      m_low = 1'b0;
      wait_us(63);
    end else begin
      wait_us(60);
      m_low = 1'b0;
      wait_us(5);
    end
  endtask

  task automatic write_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) write_bit(v[i]);
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b1;
    wait_us(3);
    m_low = 1'b0;
    wait_us(11);
    b = (dq === 1'b0) ? 1'b0 : 1'b1;
    wait_us(51);
  endtask

  task automatic read_byte(output logic [7:0] v);
    logic b;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      v[i] = b;
    end
  endtask

  task automatic reset_and_cmd(input logic [7:0] func);
    int f, l;
    bus_reset(f, l);
    write_byte(8'hCC);
    write_byte(func);
  endtask

  // reads n bytes and compares each against the expected queue
  task automatic read_and_check(input int n, input string name);
    logic [7:0] got, exp;
    for (int i = 0; i < n; i++) begin
      read_byte(got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s byte %0d: got %02h expected %02h", name, i, got, exp);
      end
    end
  endtask

  // scenarios
  task automatic test_reset();
    checks++;
    if (dq !== 1'b1) begin errors++; $display("FAIL reset_dq: got %b expected 1", dq); end
    checks++;
    if (cmd_code !== 8'h00) begin errors++; $display("FAIL reset_cmd_code: got %02h expected 00", cmd_code); end
    checks++;
    if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %b expected 0", cmd_valid); end
    checks++;
    if (conv_busy !== 1'b0) begin errors++; $display("FAIL reset_conv_busy: got %b expected 0", conv_busy); end
    checks++;
    if (rd_done !== 1'b0) begin errors++; $display("FAIL reset_rd_done: got %b expected 0", rd_done); end
    checks++;
    if (state_dbg !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, S_IDLE); end
  endtask

  task automatic test_presence();
    int f, l;
    bus_reset(f, l);
    checks++;
    if (f < 30 || f > 33) begin errors++; $display("FAIL presence_start: got %0d us expected 30..33", f); end
    checks++;
    if ((l - f + 1) < 119 || (l - f + 1) > 121) begin
      errors++; $display("FAIL presence_len: got %0d us expected 119..121", l - f + 1);
    end
    checks++;
    if (state_dbg !== S_ROM_RX) begin errors++; $display("FAIL presence_state: got %0d expected %0d", state_dbg, S_ROM_RX); end
  endtask

  task automatic test_read_scratch();
    int rd0, cmd0;
    logic b;
    logic [7:0] got;
    rd0  = rd_cnt;
    cmd0 = cmd_cnt;
    reset_and_cmd(8'hBE);
    checks++;
    if (cmd_cnt !== cmd0 + 1 || last_cmd !== 8'hBE) begin
      errors++; $display("FAIL read_cmd_valid: got count %0d code %02h expected count %0d code BE", cmd_cnt - cmd0, last_cmd, 1);
    end
    checks++;
    if (state_dbg !== S_TX) begin errors++; $display("FAIL read_state: got %0d expected %0d", state_dbg, S_TX); end
    exp_q.push_back(8'h50);
`ifdef SCRATCH_CRC_EN
    exp_q.push_back(8'h05); exp_q.push_back(8'h4B); exp_q.push_back(8'h46);
    exp_q.push_back(8'h7F); exp_q.push_back(8'hFF); exp_q.push_back(8'h0C);
    exp_q.push_back(8'h10);
    read_and_check(8, "scratch");
    exp_q.push_back(8'h1C);
    read_and_check(1, "scratch_crc");
`else
    read_and_check(1, "scratch");
    // second byte bit by bit to catch rd_done timing
    got = 8'h00;
    for (int i = 0; i < 7; i++) begin
      read_bit(b);
      got[i] = b;
    end
`endif
`ifndef SCRATCH_CRC_EN
    checks++;
    if (rd_cnt !== rd0) begin errors++; $display("FAIL rd_done_early: got %0d pulses expected 0", rd_cnt - rd0); end
    read_bit(b);
    got[7] = b;
    checks++;
    if (got !== 8'h05) begin errors++; $display("FAIL scratch byte 1: got %02h expected 05", got); end
`endif
    checks++;
    if (rd_cnt !== rd0 + 1) begin errors++; $display("FAIL rd_done_pulse: got %0d pulses expected 1", rd_cnt - rd0); end
`ifndef SCRATCH_CRC_EN
    exp_q.push_back(8'hFF);
    read_and_check(1, "post_read_released");
`endif
  endtask

  task automatic test_abort();
    int f, l, rd0;
    logic b;
    logic [4:0] got;
    rd0 = rd_cnt;
    reset_and_cmd(8'hBE);
    for (int i = 0; i < 5; i++) begin
      read_bit(b);
      got[i] = b;
    end
    checks++;
    if (got !== 5'b10000) begin errors++; $display("FAIL abort_partial: got %05b expected 10000", got); end
    bus_reset(f, l);
    checks++;
    if (f < 30 || f > 33) begin errors++; $display("FAIL abort_presence: got %0d us expected 30..33", f); end
    write_byte(8'hCC);
    write_byte(8'hBE);
    exp_q.push_back(8'h50);
    exp_q.push_back(8'h05);
    read_and_check(2, "abort_restart");
    checks++;
    if (rd_cnt !== rd0 + 1 - 1 + 1 - 1 + 1 && rd_cnt !== rd0) begin
      errors++; $display("FAIL abort_rd_done: got %0d pulses", rd_cnt - rd0);
    end
  endtask

  task automatic test_bad_rom();
    int f, l, cmd0;
    cmd0 = cmd_cnt;
    bus_reset(f, l);
    write_byte(8'h33);
    checks++;
    if (state_dbg !== S_IDLE) begin errors++; $display("FAIL badrom_state: got %0d expected %0d", state_dbg, S_IDLE); end
    exp_q.push_back(8'hFF);
    read_and_check(1, "badrom_slots");
    checks++;
    if (cmd_cnt !== cmd0) begin errors++; $display("FAIL badrom_cmd_valid: got %0d pulses expected 0", cmd_cnt - cmd0); end
  endtask

  task automatic do_convert(input logic [15:0] t, input string name);
    int cmd0;
    logic b;
    temp_raw = t;
    cmd0 = cmd_cnt;
    reset_and_cmd(8'h44);
    checks++;
    if (cmd_cnt !== cmd0 + 1 || last_cmd !== 8'h44) begin
      errors++; $display("FAIL %s_cmd: got count %0d code %02h expected count 1 code 44", name, cmd_cnt - cmd0, last_cmd);
    end
    checks++;
    if (conv_busy !== 1'b1) begin errors++; $display("FAIL %s_busy: got %b expected 1", name, conv_busy); end
    checks++;
    if (state_dbg !== S_STAT) begin errors++; $display("FAIL %s_state: got %0d expected %0d", name, state_dbg, S_STAT); end
    read_bit(b);
    checks++;
    if (b !== 1'b0) begin errors++; $display("FAIL %s_stat_busy: got %b expected 0", name, b); end
    for (int i = 0; i < 400 && conv_busy; i++) wait_us(1);
    checks++;
    if (conv_busy !== 1'b0) begin errors++; $display("FAIL %s_timeout: conv_busy still %b expected 0", name, conv_busy); end
    checks++;
    if ((busy_fall - busy_rise) < 199 * CPU || (busy_fall - busy_rise) > 201 * CPU) begin
      errors++; $display("FAIL %s_duration: got %0d cycles expected %0d", name, busy_fall - busy_rise, 200 * CPU);
    end
    read_bit(b);
    checks++;
    if (b !== 1'b1) begin errors++; $display("FAIL %s_stat_done: got %b expected 1", name, b); end
  endtask

  task automatic test_convert();
    do_convert(16'h0191, "convert");
    reset_and_cmd(8'hBE);
    exp_q.push_back(8'h91);
    exp_q.push_back(8'h01);
    read_and_check(2, "convert_readback");
  endtask

`ifdef SCRATCH_CRC_EN
  task automatic test_crc();
    logic [7:0] got;
    logic [7:0] c;
    logic       mix;
    logic [7:0] exp_b [9];
    exp_b = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};
    do_convert(16'h0550, "crc_convert");
    reset_and_cmd(8'hBE);
    c = 8'h00;
    for (int i = 0; i < 9; i++) begin
      read_byte(got);
      checks++;
      if (got !== exp_b[i]) begin errors++; $display("FAIL crc_byte %0d: got %02h expected %02h", i, got, exp_b[i]); end
      for (int k = 0; k < 8; k++) begin
        mix = c[0] ^ got[k];
        c   = c >> 1;
        if (mix) c = c ^ 8'h8C;
      end
    end
    checks++;
    if (c !== 8'h00) begin errors++; $display("FAIL crc_residue: got %02h expected 00", c); end
  endtask
`endif

  initial begin
    sys_rst_n = 1'b0;
    m_low     = 1'b0;
    temp_raw  = 16'h0550;
    repeat (5) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    wait_us(5);
    test_reset();
    test_presence();
    test_read_scratch();
    test_abort();
    test_bad_rom();
    test_convert();
`ifdef SCRATCH_CRC_EN
    test_crc();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
